// File: rtl/speech_playback_ctrl.sv
// speech_playback_ctrl: plays one stored speech segment from flash.
// Each 32-bit flash word is split into two 16-bit samples; one sample is
// released per sample_tick. Ticks that find no sample ready are counted
// as underruns (saturating). All outputs are registered.
`timescale 1ns/1ps
module speech_playback_ctrl #(
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        underrun_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, PLAY_LO, PLAY_HI, DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [31:0]       word_q, word_d;
  logic [15:0]       sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic [7:0]        ur_q, ur_d;
  logic              accept;
  logic [7:0]        ur_inc;

  // A read is taken by the slave when it is requested and not stalled.
  assign accept = read_q && !flash_waitrequest;
  // Saturating increment used for ticks that find no sample ready.
  assign ur_inc = (ur_q == 8'hFF) ? ur_q : ur_q + 8'd1;

  // Next-state, datapath and output decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    addr_d   = addr_q;
    end_d    = end_q;
    word_d   = word_q;
    sample_d = sample_q;
    ur_d     = ur_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // stop in the same cycle suppresses the command entirely.
        if (start && !stop) begin
          if (start_addr <= end_addr) begin
            addr_d  = start_addr;
            end_d   = end_addr;
            ur_d    = '0;
            state_d = FETCH;
          end else begin
            done_d = 1'b1;  // empty range completes immediately
          end
        end
      end
      FETCH: begin
        if (stop) begin
          // An accepted read still owes us a data beat, which must be drained.
          state_d = accept ? DRAIN : IDLE;
        end else begin
          if (sample_tick) ur_d = ur_inc;
          if (accept) state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (stop) begin
          // Data arriving in the stop cycle is already the outstanding beat.
          state_d = flash_readdatavalid ? IDLE : DRAIN;
        end else begin
          if (sample_tick) ur_d = ur_inc;
          if (flash_readdatavalid) begin
            word_d  = flash_readdata;
            state_d = PLAY_LO;
          end
        end
      end
      PLAY_LO: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          sample_d = word_q[15:0];
          valid_d  = 1'b1;
          state_d  = PLAY_HI;
        end
      end
      PLAY_HI: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          sample_d = word_q[31:16];
          valid_d  = 1'b1;
          if (addr_q == end_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (flash_readdatavalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered request/busy are decoded from the state being entered.
    read_d = (state_d == FETCH);
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      end_q    <= '0;
      word_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      ur_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      end_q    <= end_d;
      word_q   <= word_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      read_q   <= read_d;
      busy_q   <= busy_d;
      ur_q     <= ur_d;
    end
  end

  assign flash_read    = read_q;
  assign flash_address = addr_q;
  assign sample_out    = sample_q;
  assign sample_valid  = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign underrun_cnt  = ur_q;

endmodule

// File: tb/tb_speech_playback_ctrl.sv
// Testbench for speech_playback_ctrl. A flash slave model answers reads
// from a sparse memory; playback is checked against a sample-buffer
// occupancy model (two samples become available after each data beat,
// each tick consumes one or counts an underrun when none is available).
`timescale 1ns/1ps
module tb_speech_playback_ctrl;
  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              sample_tick = 1'b0;
  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_waitrequest = 1'b0;
  logic [31:0]       flash_readdata = '0;
  logic              flash_readdatavalid = 1'b0;
  logic [15:0]       sample_out;
  logic              sample_valid;
  logic              busy;
  logic              done;
  logic [7:0]        underrun_cnt;

  int checks = 0;
  int errors = 0;

  speech_playback_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .stop                (stop),
    .start_addr          (start_addr),
    .end_addr            (end_addr),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .sample_out          (sample_out),
    .sample_valid        (sample_valid),
    .busy                (busy),
    .done                (done),
    .underrun_cnt        (underrun_cnt)
  );

  always #5 clk = ~clk;

  // Sparse flash contents; unwritten words follow a fixed address pattern.
  logic [31:0] mem [logic [ADDR_W-1:0]];

  function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hA5C3, a[15:0] + 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Flash slave configuration and bookkeeping (owned by the slave process).
  int                lat = 1;
  int                stall_cfg = 0;
  bit                stall_rand = 1'b0;
  int                stall_left = 0;
  int                countdown = 0;
  int                reads_issued = 0;
  int                read_cycles = 0;
  int                addr_unstable = 0;
  logic [ADDR_W-1:0] resp_addr = '0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              prev_read = 1'b0;
  logic [ADDR_W-1:0] read_log [$];

  initial begin : flash_slave
    forever begin
      @(negedge clk);
      flash_readdatavalid = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          flash_readdatavalid = 1'b1;
          flash_readdata      = rd_word(resp_addr);
        end
      end
      if (flash_read) begin
        if (!prev_read) stall_left = stall_rand ? int'($urandom_range(0, 3)) : stall_cfg;
        read_cycles++;
        if (prev_read && flash_address !== prev_addr) addr_unstable++;
        if (stall_left > 0) begin
          flash_waitrequest = 1'b1;
          stall_left--;
        end else begin
          flash_waitrequest = 1'b0;
          reads_issued++;
          read_log.push_back(flash_address);
          resp_addr = flash_address;
          countdown = lat;
        end
      end else begin
        flash_waitrequest = 1'($urandom_range(0, 1));
      end
      prev_read = flash_read;
      prev_addr = flash_address;
    end
  end

  // Input values seen by the DUT at the last rising edge.
  logic tick_s, rdv_s;

  task automatic step();
    @(posedge clk);
    tick_s = sample_tick;
    rdv_s  = flash_readdatavalid;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_read"},  32'(flash_read),    32'd0);
    check({tag, "_addr"},  32'(flash_address), 32'd0);
    check({tag, "_smp"},   32'(sample_out),    32'd0);
    check({tag, "_valid"}, 32'(sample_valid),  32'd0);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_done"},  32'(done),          32'd0);
    check({tag, "_ur"},    32'(underrun_cnt),  32'd0);
  endtask

  // Full playback of [s, e] with ticks at cycle 'first' after the start
  // edge and then every pmin..pmax cycles, checked against the model.
  task automatic run_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                          input int first, input int pmin, input int pmax, input string tag);
    logic [15:0] expq [$];
    logic [15:0] exp_s;
    logic [31:0] w;
    int avail;
    int exp_ur;
    int k;
    int next_tick;
    int base;
    int nwords;
    avail     = 0;
    exp_ur    = 0;
    k         = 0;
    next_tick = first;
    base      = reads_issued;
    nwords    = int'(e - s) + 1;
    for (int i = 0; i < nwords; i++) begin
      w = rd_word(s + ADDR_W'(i));
      expq.push_back(w[15:0]);
      expq.push_back(w[31:16]);
    end
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_start_busy"}, 32'(busy),          32'd1);
    check({tag, "_start_read"}, 32'(flash_read),    32'd1);
    check({tag, "_start_addr"}, 32'(flash_address), 32'(s));
    while (expq.size() > 0 && k < 20000) begin
      k++;
      sample_tick = (k == next_tick);
      if (sample_tick) next_tick = k + int'($urandom_range(pmin, pmax));
      step();
      sample_tick = 1'b0;
      if (tick_s && avail > 0) begin
        avail--;
        exp_s = expq.pop_front();
        check({tag, "_valid"}, 32'(sample_valid), 32'd1);
        check({tag, "_sample"}, 32'(sample_out), 32'(exp_s));
        check({tag, "_done"}, 32'(done), 32'(expq.size() == 0));
      end else begin
        if (tick_s && exp_ur < 255) exp_ur++;
        check({tag, "_novalid"}, 32'(sample_valid), 32'd0);
        check({tag, "_nodone"}, 32'(done), 32'd0);
      end
      if (rdv_s) avail = 2;
    end
    check({tag, "_left"}, 32'(expq.size()), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_read"}, 32'(flash_read), 32'd0);
    check({tag, "_ur"}, 32'(underrun_cnt), 32'(exp_ur));
    check({tag, "_nreads"}, 32'(reads_issued - base), 32'(nwords));
    for (int i = 0; i < nwords && base + i < read_log.size(); i++)
      check({tag, "_raddr"}, 32'(read_log[base + i]), 32'(s + ADDR_W'(i)));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int base_rc;
    int base_un;
    bit seen;
    logic [31:0] w;
    logic [ADDR_W-1:0] rs;

    // Reset state
    step();
    step();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    step();
    check_outputs_zero("idle");

    // Normal playback: two words, 2-cycle latency, tick every 20 cycles
    mem[23'h10] = 32'hBBBB_AAAA;
    mem[23'h11] = 32'hDDDD_CCCC;
    lat = 2; stall_cfg = 0; stall_rand = 1'b0;
    run_play(23'h10, 23'h11, 20, 20, 20, "normal");
    check("normal_no_underrun", 32'(underrun_cnt), 32'd0);
    check("normal_last", 32'(sample_out), 32'hDDDD);

    // Waitrequest stall of 5 cycles
    lat = 1; stall_cfg = 5;
    base_rc = read_cycles;
    base_un = addr_unstable;
    run_play(23'h20, 23'h20, 30, 10, 10, "stall");
    check("stall_read_cycles", 32'(read_cycles - base_rc), 32'd6);
    check("stall_addr_stable", 32'(addr_unstable - base_un), 32'd0);
    stall_cfg = 0;

    // Underrun: data 50 cycles after accept, ticks every 10 cycles
    lat = 50;
    run_play(23'h30, 23'h30, 21, 10, 10, "underrun");
    check("underrun_count", 32'(underrun_cnt), 32'd4);

    // Underrun saturation: ~350 ticks before data arrives
    lat = 700;
    run_play(23'h31, 23'h31, 2, 2, 2, "sat");
    check("sat_count", 32'(underrun_cnt), 32'd255);

    // Randomized playbacks: random range, latency, stalls and tick spacing
    stall_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      lat = int'($urandom_range(1, 6));
      rs  = ADDR_W'($urandom_range(0, 4000));
      for (int i = 0; i < 4; i++) mem[rs + ADDR_W'(i)] = $urandom;
      run_play(rs, rs + ADDR_W'($urandom_range(0, 3)), int'($urandom_range(1, 10)), 2, 14, "rand");
    end
    stall_rand = 1'b0;

    // stop during WAIT_DATA: drain the outstanding beat, ignore start
    lat  = 20;
    base = reads_issued;
    start_addr = 23'h40; end_addr = 23'h41; start = 1'b1;
    step();
    start = 1'b0;
    step();                       // read accepted here
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("drain_busy_entry", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      start       = (i == 3);
      sample_tick = (i % 2 == 0);
      step();
      start       = 1'b0;
      sample_tick = 1'b0;
      seen        = rdv_s;
      check("drain_busy", 32'(busy), 32'(!rdv_s));
      check("drain_novalid", 32'(sample_valid), 32'd0);
      check("drain_nodone", 32'(done), 32'd0);
    end
    check("drain_seen_data", 32'(seen), 32'd1);
    check("drain_ur_kept", 32'(underrun_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("drain_no_restart", 32'(flash_read | busy), 32'd0);
    end
    check("drain_nreads", 32'(reads_issued - base), 32'd1);

    // Empty range: done one cycle after start, no reads
    base = reads_issued;
    start_addr = 23'd5; end_addr = 23'd4; start = 1'b1;
    step();
    start = 1'b0;
    check("empty_done", 32'(done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_read", 32'(flash_read), 32'd0);
    step();
    check("empty_done_pulse", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("empty_no_read", 32'(flash_read), 32'd0);
    end
    check("empty_nreads", 32'(reads_issued - base), 32'd0);

    // start and stop together in IDLE: no accept
    start_addr = 23'd0; end_addr = 23'd0; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_read", 32'(flash_read), 32'd0);
    check("startstop_done", 32'(done), 32'd0);

    // Mid-playback reset in PLAY_HI
    lat = 1;
    start_addr = 23'h50; end_addr = 23'h51; start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      sample_tick = (i == 0);   // lands in FETCH: one underrun
      step();
      sample_tick = 1'b0;
      seen = rdv_s;
    end
    check("mid_data_seen", 32'(seen), 32'd1);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    w = rd_word(23'h50);
    check("mid_lo_valid", 32'(sample_valid), 32'd1);
    check("mid_lo_sample", 32'(sample_out), 32'(w[15:0]));
    check("mid_ur", 32'(underrun_cnt), 32'd1);
    reset_n     = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_outputs_zero("midreset");
    reset_n = 1'b1;
    step();
    check_outputs_zero("midreset_idle");

    // Reset while a read is outstanding: the late data beat is ignored
    lat = 5;
    start_addr = 23'h60; end_addr = 23'h60; start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("late_rdv_busy", 32'(busy), 32'd0);
      check("late_rdv_valid", 32'(sample_valid), 32'd0);
      check("late_rdv_read", 32'(flash_read), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speech_playback_ctrl.md
# speech_playback_ctrl

Sequences playback of one stored speech segment from flash to the audio path. It fetches 32-bit flash words over an Avalon-MM-style read port and splits each word into two 16-bit samples. One sample is released per `sample_tick`, which is the single-cycle sample-rate strobe produced by the pulse synchronizer in the `clk` domain. It sits between the command logic, which supplies address ranges, and the audio output, and tracks missed ticks as underruns.

## Interface
- `ADDR_W`, 23, flash word-address width.
- `clk` in 1, system clock; all logic is in this domain.
- `reset_n` in 1, synchronous, active-low reset.
- `start` in 1, single-cycle command; accepted only in IDLE.
- `stop` in 1, abort current playback; priority over `start` and `sample_tick`.
- `start_addr` in ADDR_W, first word address; sampled when `start` is accepted.
- `end_addr` in ADDR_W, last word address (inclusive); sampled when `start` is accepted.
- `sample_tick` in 1, single-cycle sample strobe, already synchronized to `clk`.
- `flash_read` out 1, read request.
- `flash_address` out ADDR_W, word address of the current read.
- `flash_waitrequest` in 1, slave stall; a read is accepted on a cycle with `flash_read=1` and `flash_waitrequest=0`.
- `flash_readdata` in 32, read data.
- `flash_readdatavalid` in 1, read data valid.
- `sample_out` out 16, current audio sample; holds its value between updates.
- `sample_valid` out 1, single-cycle pulse when `sample_out` updates.
- `busy` out 1, high in every state except IDLE.
- `done` out 1, single-cycle pulse on normal completion.
- `underrun_cnt` out 8, saturating count of ticks that found no sample ready.

## Operation
- **Reset state:** all outputs are 0 and the FSM is in IDLE. Reset overrides everything on the same edge, including mid-read. A `flash_readdatavalid` arriving after reset is ignored.
- **FSM states:** IDLE, FETCH, WAIT_DATA, PLAY_LO, PLAY_HI, DRAIN.
- **IDLE:**
  - `start` with `start_addr <= end_addr`: latch both addresses, clear `underrun_cnt`, set `flash_address = start_addr`, go to FETCH.
  - `start` with `start_addr > end_addr`: pulse `done` on the next cycle, perform no reads, stay in IDLE.
- **FETCH:**
  - `flash_read=1`, and `flash_address` is held stable until the read is accepted.
  - On accept, go to WAIT_DATA; `flash_read` drops on the next cycle.
- **WAIT_DATA:** on `flash_readdatavalid`, latch `flash_readdata` into the word buffer and go to PLAY_LO.
- **PLAY_LO:** on `sample_tick`, set `sample_out <= word[15:0]`, pulse `sample_valid`, go to PLAY_HI.
- **PLAY_HI:** on `sample_tick`, set `sample_out <= word[31:16]` and pulse `sample_valid`. Then:
  - if `flash_address == end_addr`: pulse `done` in the same cycle as `sample_valid` and go to IDLE;
  - otherwise: increment `flash_address` and go to FETCH.
  - Addresses never wrap, because the end compare always terminates playback first.
- **Underrun:**
  - A `sample_tick` in FETCH or WAIT_DATA increments `underrun_cnt`, saturating at 255.
  - `sample_out` is held and there is no `sample_valid`.
  - Ticks in IDLE or DRAIN are ignored.
- **stop:**
  - From PLAY_LO, PLAY_HI, or FETCH with no accept that cycle: go to IDLE; `flash_read` drops on the next cycle.
  - From WAIT_DATA, or from FETCH on an accept cycle: go to DRAIN.
  - DRAIN waits for `flash_readdatavalid`, discards the data, then goes to IDLE.
  - `done` is not pulsed on stop. `sample_out` and `underrun_cnt` keep their values.
- **Ignored inputs:** `start` outside IDLE is ignored; it is not queued. `stop` in IDLE has no effect.

## Timing
- **Outputs:** all outputs are registered.
- **start to read:** `start` accepted at edge N gives `flash_read=1`, with `flash_address=start_addr`, after edge N.
- **Read hold:** read is held for as many cycles as `flash_waitrequest` is high; zero-wait accept takes 1 cycle in FETCH.
- **Data to ready:** `flash_readdatavalid` at edge M puts the FSM in PLAY_LO after M. A tick coincident with that edge counts as an underrun.
- **Tick to sample:** tick at edge T gives `sample_out`/`sample_valid` after T, i.e. 1-cycle latency.
- **Simultaneous events:** `stop` and `sample_tick` in the same PLAY cycle give no sample and go to IDLE. `stop` and `start` in IDLE give no accept.
- **Next-word fetch:** the next word's FETCH begins the cycle after the PLAY_HI tick. At ≥8 cycles per tick with 1-cycle flash latency, no underruns occur.

## Test plan
- **Normal playback:**
  - Stimulus: `start_addr=0x10`, `end_addr=0x11`; flash returns 0xBBBBAAAA and 0xDDDDCCCC with 2-cycle latency; ticks every 20 cycles.
  - Required: `sample_out` sequence 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD; `done` coincides with the 4th `sample_valid`; `underrun_cnt=0`.
- **Waitrequest stall:**
  - Stimulus: `flash_waitrequest` high for 5 cycles.
  - Required: `flash_read` held for 6 cycles with address constant; exactly one read issued.
- **Underrun:**
  - Stimulus: `flash_readdatavalid` delayed 50 cycles; ticks every 10 cycles.
  - Required: `underrun_cnt=4` (the tick coincident with `flash_readdatavalid` counts); no `sample_valid` before the data arrives.
  - Saturation: 300 such ticks give `underrun_cnt=255`.
- **stop during WAIT_DATA:**
  - Required: FSM goes to DRAIN; `busy` stays high until `flash_readdatavalid`; no `sample_valid`, no `done`; a `start` issued during DRAIN is ignored.
- **Empty range:**
  - Stimulus: `start_addr=5`, `end_addr=4`.
  - Required: `done` one cycle after `start`, `flash_read` never asserted.
- **Mid-playback reset:**
  - Stimulus: `reset_n` low in PLAY_HI.
  - Required: next cycle all outputs 0 and FSM in IDLE.
